// File: rtl/program_counter.sv
// Fetch-stage program counter: a WIDTH-bit register loaded when en is high,
// plus the combinational sequential next address (PC + INCREMENT).
module program_counter #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               INCREMENT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] dataInput,
  output logic [WIDTH-1:0] dataOutput,
  output logic [WIDTH-1:0] dataOutputPlus4
);

  logic [WIDTH-1:0] pc_q;

  // An unknown en falls to the else branch in simulation, so the PC holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VALUE;
    end else if (en) begin
      pc_q <= dataInput;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign dataOutput      = pc_q;
  assign dataOutputPlus4 = pc_q + WIDTH'(INCREMENT);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized
// load/stall/reset traffic against a behavioural PC model, on two reset vectors.
module tb_program_counter;

  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] dataInput;
  logic [31:0] out0, out0_p4;
  logic [31:0] out1, out1_p4;

  int total;
  int bad;

  logic [31:0] exp_q[$];

  program_counter dut0 (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .dataInput       (dataInput),
    .dataOutput      (out0),
    .dataOutputPlus4 (out0_p4)
  );

  program_counter #(.RESET_VALUE(RV1)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .dataInput       (dataInput),
    .dataOutput      (out1),
    .dataOutputPlus4 (out1_p4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    dataInput = 32'h1234;
  end

  // driver: advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (out0 !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out0, 32'h0); end
    total++;
    if (out0_p4 !== 32'h4) begin bad++; $display("FAIL reset_p4 got=%h exp=%h", out0_p4, 32'h4); end
    step();
    step();
    total++;
    if (out0 !== 32'h0) begin bad++; $display("FAIL reset_hold got=%h exp=%h", out0, 32'h0); end
  endtask

  task automatic test_param_override();
    total++;
    if (out1 !== 32'h0040_0000) begin bad++; $display("FAIL param_rv got=%h exp=%h", out1, 32'h0040_0000); end
    total++;
    if (out1_p4 !== 32'h0040_0004) begin bad++; $display("FAIL param_p4 got=%h exp=%h", out1_p4, 32'h0040_0004); end
  endtask

  task automatic test_release();
    // release between edges with en high: nothing loads until the next edge
    @(negedge clk);
    rst       = 1'b1;
    dataInput = 32'h55;
    #1;
    total++;
    if (out0 !== 32'h0) begin bad++; $display("FAIL release_noload got=%h exp=%h", out0, 32'h0); end
  endtask

  task automatic test_load();
    en        = 1'b1;
    dataInput = 32'hA;
    step();
    total++;
    if (out0 !== 32'hA) begin bad++; $display("FAIL load_a got=%h exp=%h", out0, 32'hA); end
    total++;
    if (out0_p4 !== 32'hE) begin bad++; $display("FAIL load_a_p4 got=%h exp=%h", out0_p4, 32'hE); end
    dataInput = 32'hF;
    step();
    total++;
    if (out0 !== 32'hF) begin bad++; $display("FAIL load_f got=%h exp=%h", out0, 32'hF); end
  endtask

  task automatic test_stall();
    en        = 1'b0;
    dataInput = 32'hF0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out0 !== 32'hF) begin bad++; $display("FAIL stall_%0d got=%h exp=%h", i, out0, 32'hF); end
    end
    en = 1'b1;
    step();
    total++;
    if (out0 !== 32'hF0) begin bad++; $display("FAIL stall_resume got=%h exp=%h", out0, 32'hF0); end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (out0 !== 32'h0) begin bad++; $display("FAIL async_mid got=%h exp=%h", out0, 32'h0); end
    total++;
    if (out1 !== RV1) begin bad++; $display("FAIL async_mid_rv1 got=%h exp=%h", out1, RV1); end
    #2;
    rst       = 1'b1;
    en        = 1'b1;
    dataInput = 32'h8;
    step();
    total++;
    if (out0 !== 32'h8) begin bad++; $display("FAIL async_reload got=%h exp=%h", out0, 32'h8); end
  endtask

  task automatic test_reset_at_edge();
    en        = 1'b1;
    dataInput = 32'h77;
    @(posedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out0 !== 32'h0) begin bad++; $display("FAIL reset_edge got=%h exp=%h", out0, 32'h0); end
    #2;
    rst = 1'b1;
  endtask

  task automatic test_wrap();
    en        = 1'b1;
    dataInput = 32'hFFFF_FFFC;
    step();
    total++;
    if (out0 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h exp=%h", out0, 32'hFFFF_FFFC); end
    total++;
    if (out0_p4 !== 32'h0) begin bad++; $display("FAIL wrap_p4 got=%h exp=%h", out0_p4, 32'h0); end
    dataInput = 32'h0;
    step();
    total++;
    if (out0 !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=%h", out0, 32'h0); end
    total++;
    if (out0_p4 !== 32'h4) begin bad++; $display("FAIL wrap_zero_p4 got=%h exp=%h", out0_p4, 32'h4); end
  endtask

  // Reference model: PC is the reset vector after reset, else the last value
  // presented on an enabled edge; next address is PC + 4 modulo 2^32.
  task automatic test_random();
    logic [31:0] pc0, pc1, exp;
    logic [31:0] got;
    logic        do_rst;
    pc0 = out0;
    pc1 = out1;
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       dataInput = 32'hFFFF_FFFC - ($urandom_range(0, 3) * 4);
        1:       dataInput = $urandom_range(0, 15);
        default: dataInput = $urandom;
      endcase
      do_rst = ($urandom_range(0, 19) == 0);
      step();
      if (en) begin
        pc0 = dataInput;
        pc1 = dataInput;
      end
      if (do_rst) begin
        rst = 1'b0;
        #1;
        pc0 = RV0;
        pc1 = RV1;
        #1;
        rst = 1'b1;
      end
      exp_q.push_back(pc0);
      exp_q.push_back(pc0 + 32'd4);
      exp_q.push_back(pc1);
      exp_q.push_back(pc1 + 32'd4);
      for (int k = 0; k < 4; k++) begin
        exp = exp_q.pop_front();
        case (k)
          0:       got = out0;
          1:       got = out0_p4;
          2:       got = out1;
          default: got = out1_p4;
        endcase
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL rand_%0d_%0d got=%h exp=%h", i, k, got, exp);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_param_override();
    test_release();
    test_load();
    test_stall();
    test_async_reset();
    test_reset_at_edge();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
